chain_master: RTL

CHAIN_MASTER -- requirements
Module: chain_master

---
 rtl/chain_master_pkg.sv | 60 ++++++
 rtl/chain_master_shift.sv | 48 ++++
 rtl/includes.svh | 21 ++
 rtl/chain_master.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/chain_master_pkg.sv
// +----------------------------------------------------------------------+
// | chain_master_pkg                                                     |
// | Shared types, command codes and default timing for the daisychain.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`include "includes.svh"
`default_nettype none

package chain_master_pkg;

    localparam int c_CMD_LEN      = `CMD_LEN;
    localparam int c_DATA_LEN     = `DATA_LEN;

    // Default phase lengths of the master
    localparam int c_ACK_CYCLES   = 2;
    localparam int c_TURN_CYCLES  = 2;
    localparam int c_GAP_CYCLES   = 4;

    // Command codes understood by the chain nodes
    localparam logic [c_CMD_LEN-1:0] RESET_CMD     = c_CMD_LEN'(0);
    localparam logic [c_CMD_LEN-1:0] UPDATE_CMD    = c_CMD_LEN'(1);
    localparam logic [c_CMD_LEN-1:0] START_RCV_CMD = c_CMD_LEN'(2);
    localparam logic [c_CMD_LEN-1:0] START_SND_CMD = c_CMD_LEN'(3);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_CMD     = 3'd2,
        ST_ACK     = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_TURN    = 3'd5,
        ST_RD_DATA = 3'd6,
        ST_GAP     = 3'd7
    } master_state_t;

    // Node-side controller states
    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_CMD  = 2'd1,
        CTRL_DATA = 2'd2,
        CTRL_FWD  = 2'd3
    } ctrl_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic cmd_is_known(input logic [c_CMD_LEN-1:0] cmd);
        return (cmd == RESET_CMD) || (cmd == UPDATE_CMD) ||
               (cmd == START_RCV_CMD) || (cmd == START_SND_CMD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chain_master_shift.sv
// +----------------------------------------------------------------------+
// | piso_sipo_shift                                                      |
// | Shared shift register: parallel-load/serial-out for writes and       |
// | serial-in/parallel-out for reads. Exposes the next-cycle word so the |
// | caller can register line outputs in step with the state machine.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module piso_sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_word_next
);

    logic [WIDTH-1:0] r_word_q;
    logic [WIDTH-1:0] w_word_d;

    // Load has priority; a shift moves toward the MSB, taking the new bit at the LSB
    always_comb begin
        w_word_d = r_word_q;
        if (i_load) begin
            w_word_d = i_load_data;
        end else if (i_shift) begin
            w_word_d = {r_word_q[WIDTH-2:0], i_ser_in};
        end
    end

    // Shift register storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_q <= '0;
        end else begin
            r_word_q <= w_word_d;
        end
    end

    assign o_word_next = w_word_d;

endmodule

`default_nettype wire

// File: rtl/includes.svh
// +----------------------------------------------------------------------+
// | includes.svh                                                         |
// | Global field widths for the daisychain command/data frames.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

`ifndef CHAIN_INCLUDES_SVH
`define CHAIN_INCLUDES_SVH

`ifndef CMD_LEN
`define CMD_LEN 2
`endif

`ifndef DATA_LEN
`define DATA_LEN 8
`endif

`endif

`default_nettype wire

// File: rtl/chain_master.sv
// +----------------------------------------------------------------------+
// | chain_master                                                         |
// | Host-side master for the daisychain serial line: START, command,     |
// | ACK, then write data or turnaround + read data, then a driven gap.   |
// | Optional macro CHAIN_MASTER_CMD_CHECK_EN: unknown commands skip the  |
// | line entirely and complete with rsp_err.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module chain_master
    import chain_master_pkg::*;
#(
    parameter int ACK_CYCLES  = c_ACK_CYCLES,
    parameter int TURN_CYCLES = c_TURN_CYCLES,
    parameter int GAP_CYCLES  = c_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire                   data_inout,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [c_CMD_LEN-1:0]  req_cmd,
    input  logic [c_DATA_LEN-1:0] req_data,
    output logic                  rsp_valid,
    output logic [c_DATA_LEN-1:0] rsp_data,
`ifdef CHAIN_MASTER_CMD_CHECK_EN
    output logic                  rsp_err,
`endif
    output logic                  busy
);

    localparam int c_CNT_W = $clog2(max4(c_DATA_LEN, ACK_CYCLES, TURN_CYCLES, GAP_CYCLES) + 1);

    master_state_t         r_state_q,    w_state_d;
    logic [c_CNT_W-1:0]    r_cnt_q,      w_cnt_d;
    logic [c_CMD_LEN-1:0]  r_cmd_q,      w_cmd_d;
    logic [c_CMD_LEN-1:0]  r_cmd_sh_q,   w_cmd_sh_d;
    logic                  r_line_q,     w_line_d;
    logic                  r_oe_q,       w_oe_d;
    logic                  r_ready_q,    w_ready_d;
    logic                  r_busy_q,     w_busy_d;
    logic                  r_rsp_valid_q, w_rsp_valid_d;
    logic [c_DATA_LEN-1:0] r_rsp_data_q, w_rsp_data_d;
`ifdef CHAIN_MASTER_CMD_CHECK_EN
    logic                  r_err_q,      w_err_d;
`endif
    logic                  w_load;
    logic                  w_shift;
    logic [c_DATA_LEN-1:0] w_word_next;

    piso_sipo_shift #(
        .WIDTH (c_DATA_LEN)
    ) u_shift (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_load),
        .i_load_data (req_data),
        .i_shift     (w_shift),
        .i_ser_in    (data_inout),
        .o_word_next (w_word_next)
    );

    // Next state, phase counter and command shifter
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = '0;
        w_cmd_d    = r_cmd_q;
        w_cmd_sh_d = r_cmd_sh_q;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid && r_ready_q) begin
                    w_cmd_d    = req_cmd;
                    w_cmd_sh_d = req_cmd;
                    w_load     = 1'b1;
                    w_state_d  = ST_START;
`ifdef CHAIN_MASTER_CMD_CHECK_EN
                    if (!cmd_is_known(req_cmd)) w_state_d = ST_GAP;
`endif
                end
            end
            ST_START: w_state_d = ST_CMD;
            ST_CMD: begin
                w_cmd_sh_d = r_cmd_sh_q << 1;
                if (r_cnt_q == c_CNT_W'(c_CMD_LEN - 1)) w_state_d = ST_ACK;
                else                                    w_cnt_d   = r_cnt_q + 1'b1;
            end
            ST_ACK: begin
                if (r_cnt_q == c_CNT_W'(ACK_CYCLES - 1)) begin
                    case (r_cmd_q)
                        START_RCV_CMD: w_state_d = ST_WR_DATA;
                        START_SND_CMD: w_state_d = ST_TURN;
                        default:       w_state_d = ST_GAP;
                    endcase
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_WR_DATA: begin
                w_shift = 1'b1;
                if (r_cnt_q == c_CNT_W'(c_DATA_LEN - 1)) w_state_d = ST_GAP;
                else                                     w_cnt_d   = r_cnt_q + 1'b1;
            end
            ST_TURN: begin
                if (r_cnt_q == c_CNT_W'(TURN_CYCLES - 1)) w_state_d = ST_RD_DATA;
                else                                      w_cnt_d   = r_cnt_q + 1'b1;
            end
            ST_RD_DATA: begin
                w_shift = 1'b1;
                if (r_cnt_q == c_CNT_W'(c_DATA_LEN - 1)) w_state_d = ST_GAP;
                else                                     w_cnt_d   = r_cnt_q + 1'b1;
            end
            ST_GAP: begin
                if (r_cnt_q == c_CNT_W'(GAP_CYCLES - 1)) w_state_d = ST_IDLE;
                else                                     w_cnt_d   = r_cnt_q + 1'b1;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered line tracks the state
    always_comb begin
        w_line_d = 1'b0;
        w_oe_d   = 1'b1;
        case (w_state_d)
            ST_START:   w_line_d = 1'b1;
            ST_CMD:     w_line_d = w_cmd_sh_d[c_CMD_LEN-1];
            ST_WR_DATA: w_line_d = w_word_next[c_DATA_LEN-1];
            ST_TURN,
            ST_RD_DATA: w_oe_d   = 1'b0;
            default:    w_line_d = 1'b0;
        endcase
        w_ready_d     = (w_state_d == ST_IDLE);
        w_busy_d      = (w_state_d != ST_IDLE);
        w_rsp_valid_d = (w_state_d == ST_GAP) && (r_state_q != ST_GAP);
        w_rsp_data_d  = r_rsp_data_q;
        if (w_rsp_valid_d) begin
            w_rsp_data_d = (r_state_q == ST_RD_DATA) ? w_word_next : '0;
        end
`ifdef CHAIN_MASTER_CMD_CHECK_EN
        w_err_d = w_rsp_valid_d && (r_state_q == ST_IDLE);
`endif
    end

    // Master state machine and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_cmd_q       <= '0;
            r_cmd_sh_q    <= '0;
            r_line_q      <= 1'b0;
            r_oe_q        <= 1'b1;
            r_ready_q     <= 1'b0;
            r_busy_q      <= 1'b0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_data_q  <= '0;
`ifdef CHAIN_MASTER_CMD_CHECK_EN
            r_err_q       <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_cmd_q       <= w_cmd_d;
            r_cmd_sh_q    <= w_cmd_sh_d;
            r_line_q      <= w_line_d;
            r_oe_q        <= w_oe_d;
            r_ready_q     <= w_ready_d;
            r_busy_q      <= w_busy_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_data_q  <= w_rsp_data_d;
`ifdef CHAIN_MASTER_CMD_CHECK_EN
            r_err_q       <= w_err_d;
`endif
        end
    end

    assign data_inout = r_oe_q ? r_line_q : 1'bz;
    assign req_ready  = r_ready_q;
    assign busy       = r_busy_q;
    assign rsp_valid  = r_rsp_valid_q;
    assign rsp_data   = r_rsp_data_q;
`ifdef CHAIN_MASTER_CMD_CHECK_EN
    assign rsp_err    = r_err_q;
`endif

endmodule

`default_nettype wire
